// File: rtl/uart_ahb_pkg.sv
// Shared AHB-Lite encodings and bridge state type for the UART AHB front end.
package uart_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [2:0] {IDLE, WR, RD1, RD2, ER1, ER2} state_t;

endpackage

// File: rtl/uart_ahb_if.sv
// AHB-Lite signal bundle between the interconnect and the UART bridge.
interface uart_ahb_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HREADY, HRDATA, HREADYOUT, HRESP
    );

endinterface

// File: rtl/uart_ahb_lane.sv
// Byte-lane steering between the 32-bit AHB data buses and the 8-bit register port.
module uart_ahb_lane (
    input  logic        endian,
    input  logic [31:0] wdata,
    output logic [7:0]  wbyte,
    input  logic [7:0]  rbyte,
    output logic [31:0] rword
);

    logic unused_wdata;

    assign unused_wdata = ^wdata[23:8];

    assign wbyte = endian ? wdata[31:24] : wdata[7:0];
    assign rword = endian ? {rbyte, 24'h000000} : {24'h000000, rbyte};

endmodule

// File: rtl/uart_ahb_bridge.sv
// AHB-Lite slave front end for the 16550 register file: one strobe per accepted
// transfer, registered read data with a single wait state, ERROR for wide accesses.
module uart_ahb_bridge
    import uart_ahb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 5,
    parameter bit ERR_ON_WIDE = 1'b1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    uart_ahb_if.slave             ahb,
    input  logic                  SI_Endian,
    output logic [ADDR_WIDTH-3:0] reg_adr,
    output logic [7:0]            reg_dat_o,
    input  logic [7:0]            reg_dat_i,
    output logic                  reg_we,
    output logic                  reg_re
);

    state_t                state, state_nx;
    logic                  accept;
    logic                  wide;
    logic                  ready_st;
    logic [ADDR_WIDTH-3:0] adr_q;
    logic                  end_q;
    logic [7:0]            rdata;
    logic [7:0]            wbyte;
    logic [31:0]           rword;
    logic                  unused_haddr;

    assign unused_haddr = ^{ahb.HADDR[31:ADDR_WIDTH], ahb.HADDR[1:0]};

    assign accept   = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
    assign wide     = (ahb.HSIZE != HSIZE_BYTE);
    // Only states that complete their data phase this cycle may take a new address phase.
    assign ready_st = (state == IDLE) || (state == WR) || (state == RD2) || (state == ER2);

    always_comb begin
        state_nx = IDLE;
        case (state)
            RD1:     state_nx = RD2;
            ER1:     state_nx = ER2;
            default: begin
                if (ready_st && accept) begin
                    if (ERR_ON_WIDE && wide) state_nx = ER1;
                    else if (ahb.HWRITE)     state_nx = WR;
                    else                     state_nx = RD1;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state <= IDLE;
            adr_q <= '0;
            end_q <= 1'b0;
            rdata <= '0;
        end else begin
            state <= state_nx;
            if (ready_st && accept) begin
                adr_q <= ahb.HADDR[ADDR_WIDTH-1:2];
                end_q <= SI_Endian;
            end
            if (state == RD1) rdata <= reg_dat_i;
        end
    end

    uart_ahb_lane u_lane (
        .endian (end_q),
        .wdata  (ahb.HWDATA),
        .wbyte  (wbyte),
        .rbyte  (rdata),
        .rword  (rword)
    );

    // Every output is a decode of registered state; write data is the live data-phase lane.
    always_comb begin
        reg_adr       = adr_q;
        reg_we        = (state == WR);
        reg_re        = (state == RD1);
        reg_dat_o     = (state == WR) ? wbyte : 8'h00;
        ahb.HREADYOUT = !((state == RD1) || (state == ER1));
        ahb.HRESP     = (state == ER1) || (state == ER2);
        ahb.HRDATA    = (state == RD2) ? rword : 32'h00000000;
    end

endmodule

// File: tb/tb_uart_ahb_bridge.sv
// Directed bench for uart_ahb_bridge: inputs change 1 time unit after HCLK rises,
// outputs are checked on the falling edge of the same cycle.
module tb_uart_ahb_bridge;
    import uart_ahb_pkg::*;

    logic       HCLK;
    logic       HRESETn;
    logic       SI_Endian;
    logic [2:0] reg_adr;
    logic [7:0] reg_dat_o;
    logic [7:0] reg_dat_i;
    logic       reg_we;
    logic       reg_re;

    int checks;
    int failures;
    int ws;

    uart_ahb_if ahb ();

    assign ahb.HREADY = ahb.HREADYOUT;

    uart_ahb_bridge #(.ADDR_WIDTH(5), .ERR_ON_WIDE(1'b1)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .ahb       (ahb),
        .SI_Endian (SI_Endian),
        .reg_adr   (reg_adr),
        .reg_dat_o (reg_dat_o),
        .reg_dat_i (reg_dat_i),
        .reg_we    (reg_we),
        .reg_re    (reg_re)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge HCLK);
        #1;
    endtask

    task automatic mid();
        @(negedge HCLK);
    endtask

    task automatic addr_ph(input logic sel, input logic [1:0] tr, input logic wr,
                           input logic [2:0] sz, input logic [31:0] a);
        ahb.HSEL   = sel;
        ahb.HTRANS = tr;
        ahb.HWRITE = wr;
        ahb.HSIZE  = sz;
        ahb.HADDR  = a;
    endtask

    task automatic bus_idle();
        addr_ph(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 32'h0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        ws        = 0;
        HRESETn   = 1'b0;
        SI_Endian = 1'b0;
        reg_dat_i = 8'h00;
        ahb.HWDATA = 32'h0;
        bus_idle();

        // Reset state
        repeat (2) adv();
        mid();
        chk("rst_hreadyout", {31'd0, ahb.HREADYOUT}, 32'd1);
        chk("rst_hresp",     {31'd0, ahb.HRESP},     32'd0);
        chk("rst_hrdata",    ahb.HRDATA,             32'h0);
        chk("rst_we",        {31'd0, reg_we},        32'd0);
        chk("rst_re",        {31'd0, reg_re},        32'd0);
        chk("rst_adr",       {29'd0, reg_adr},       32'd0);
        chk("rst_dat_o",     {24'd0, reg_dat_o},     32'd0);
        adv();
        HRESETn = 1'b1;

        // Little-endian byte write to index 3
        adv();
        addr_ph(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h0000000C);
        mid();
        chk("wr_le_pre_we", {31'd0, reg_we}, 32'd0);
        adv();
        bus_idle();
        ahb.HWDATA = 32'h00000083;
        mid();
        chk("wr_le_we",    {31'd0, reg_we},        32'd1);
        chk("wr_le_re",    {31'd0, reg_re},        32'd0);
        chk("wr_le_adr",   {29'd0, reg_adr},       32'd3);
        chk("wr_le_dat",   {24'd0, reg_dat_o},     32'h83);
        chk("wr_le_ready", {31'd0, ahb.HREADYOUT}, 32'd1);
        adv();
        ahb.HWDATA = 32'hFFFFFFFF;
        mid();
        chk("wr_le_post_we", {31'd0, reg_we}, 32'd0);

        // Big-endian byte read from index 0; endian bit is latched with the address
        adv();
        SI_Endian = 1'b1;
        reg_dat_i = 8'h5A;
        addr_ph(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_BYTE, 32'h00000000);
        mid();
        adv();
        bus_idle();
        SI_Endian = 1'b0;
        mid();
        chk("rd_be_rd1_re",    {31'd0, reg_re},        32'd1);
        chk("rd_be_rd1_ready", {31'd0, ahb.HREADYOUT}, 32'd0);
        chk("rd_be_rd1_adr",   {29'd0, reg_adr},       32'd0);
        chk("rd_be_rd1_resp",  {31'd0, ahb.HRESP},     32'd0);
        adv();
        reg_dat_i = 8'h00;
        mid();
        chk("rd_be_rd2_data",  ahb.HRDATA,             32'h5A000000);
        chk("rd_be_rd2_ready", {31'd0, ahb.HREADYOUT}, 32'd1);
        chk("rd_be_rd2_re",    {31'd0, reg_re},        32'd0);
        adv();
        mid();
        chk("rd_be_post_re", {31'd0, reg_re}, 32'd0);

        // Wide word write, then a halfword read issued during the second ERROR cycle
        adv();
        addr_ph(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h00000004);
        mid();
        adv();
        bus_idle();
        ahb.HWDATA = 32'h12345678;
        mid();
        chk("wide_er1_resp",  {31'd0, ahb.HRESP},     32'd1);
        chk("wide_er1_ready", {31'd0, ahb.HREADYOUT}, 32'd0);
        chk("wide_er1_we",    {31'd0, reg_we},        32'd0);
        adv();
        addr_ph(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_HALF, 32'h00000000);
        mid();
        chk("wide_er2_resp",  {31'd0, ahb.HRESP},     32'd1);
        chk("wide_er2_ready", {31'd0, ahb.HREADYOUT}, 32'd1);
        chk("wide_er2_we",    {31'd0, reg_we},        32'd0);
        adv();
        bus_idle();
        mid();
        chk("half_er1_resp",  {31'd0, ahb.HRESP},     32'd1);
        chk("half_er1_ready", {31'd0, ahb.HREADYOUT}, 32'd0);
        chk("half_er1_re",    {31'd0, reg_re},        32'd0);
        adv();
        mid();
        chk("half_er2_resp",  {31'd0, ahb.HRESP},     32'd1);
        chk("half_er2_re",    {31'd0, reg_re},        32'd0);
        adv();
        mid();
        chk("err_done_resp",  {31'd0, ahb.HRESP},     32'd0);
        chk("err_done_ready", {31'd0, ahb.HREADYOUT}, 32'd1);

        // Pipelined: write 0x11 @1, write 0x22 @2, read @1 back to back
        adv();
        SI_Endian = 1'b0;
        addr_ph(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h00000004);
        mid();
        adv();
        addr_ph(1'b1, HTRANS_SEQ, 1'b1, HSIZE_BYTE, 32'h00000008);
        ahb.HWDATA = 32'hEEEEEE11;
        mid();
        if (ahb.HREADYOUT === 1'b0) ws++;
        chk("pipe_c1_we",  {31'd0, reg_we},    32'd1);
        chk("pipe_c1_adr", {29'd0, reg_adr},   32'd1);
        chk("pipe_c1_dat", {24'd0, reg_dat_o}, 32'h11);
        adv();
        addr_ph(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_BYTE, 32'h00000004);
        ahb.HWDATA = 32'h00000022;
        mid();
        if (ahb.HREADYOUT === 1'b0) ws++;
        chk("pipe_c2_we",  {31'd0, reg_we},    32'd1);
        chk("pipe_c2_adr", {29'd0, reg_adr},   32'd2);
        chk("pipe_c2_dat", {24'd0, reg_dat_o}, 32'h22);
        adv();
        bus_idle();
        ahb.HWDATA = 32'h0;
        reg_dat_i = 8'h11;
        mid();
        if (ahb.HREADYOUT === 1'b0) ws++;
        chk("pipe_c3_re",  {31'd0, reg_re},  32'd1);
        chk("pipe_c3_we",  {31'd0, reg_we},  32'd0);
        chk("pipe_c3_adr", {29'd0, reg_adr}, 32'd1);
        adv();
        reg_dat_i = 8'h00;
        mid();
        if (ahb.HREADYOUT === 1'b0) ws++;
        chk("pipe_c4_data", ahb.HRDATA,      32'h00000011);
        chk("pipe_c4_re",   {31'd0, reg_re}, 32'd0);
        adv();
        mid();
        if (ahb.HREADYOUT === 1'b0) ws++;
        chk("pipe_waits", ws, 32'd1);

        // Big-endian write; address bits above the decoded field are ignored
        adv();
        SI_Endian = 1'b1;
        addr_ph(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'hFFFFFF1C);
        mid();
        adv();
        bus_idle();
        SI_Endian = 1'b0;
        ahb.HWDATA = 32'hA53CC300;
        mid();
        chk("wr_be_we",  {31'd0, reg_we},    32'd1);
        chk("wr_be_adr", {29'd0, reg_adr},   32'd7);
        chk("wr_be_dat", {24'd0, reg_dat_o}, 32'hA5);

        // IDLE and BUSY while selected, NONSEQ while unselected: no strobes
        adv();
        addr_ph(1'b1, HTRANS_IDLE, 1'b1, HSIZE_BYTE, 32'h0000000C);
        mid();
        adv();
        addr_ph(1'b1, HTRANS_BUSY, 1'b1, HSIZE_BYTE, 32'h0000000C);
        mid();
        chk("idle_we",    {31'd0, reg_we},        32'd0);
        chk("idle_ready", {31'd0, ahb.HREADYOUT}, 32'd1);
        adv();
        addr_ph(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h0000000C);
        mid();
        chk("busy_we",    {31'd0, reg_we},        32'd0);
        chk("busy_resp",  {31'd0, ahb.HRESP},     32'd0);
        adv();
        addr_ph(1'b0, HTRANS_NONSEQ, 1'b0, HSIZE_BYTE, 32'h00000000);
        mid();
        chk("unsel_we",    {31'd0, reg_we},        32'd0);
        chk("unsel_ready", {31'd0, ahb.HREADYOUT}, 32'd1);
        adv();
        bus_idle();
        mid();
        chk("unsel_re",   {31'd0, reg_re},    32'd0);
        chk("unsel_resp", {31'd0, ahb.HRESP}, 32'd0);

        // Reset asserted while in RD1 drops the read
        adv();
        reg_dat_i = 8'h77;
        addr_ph(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_BYTE, 32'h00000008);
        mid();
        adv();
        bus_idle();
        mid();
        chk("rstrd_rd1_re", {31'd0, reg_re}, 32'd1);
        HRESETn = 1'b0;
        adv();
        mid();
        chk("rstrd_re",     {31'd0, reg_re},        32'd0);
        chk("rstrd_ready",  {31'd0, ahb.HREADYOUT}, 32'd1);
        chk("rstrd_hrdata", ahb.HRDATA,             32'h0);
        chk("rstrd_adr",    {29'd0, reg_adr},       32'd0);
        HRESETn = 1'b1;
        adv();
        mid();
        chk("rstrd_after_re",     {31'd0, reg_re},        32'd0);
        chk("rstrd_after_hrdata", ahb.HRDATA,             32'h0);
        chk("rstrd_after_ready",  {31'd0, ahb.HREADYOUT}, 32'd1);
        adv();
        mid();
        chk("rstrd_late_re", {31'd0, reg_re}, 32'd0);
        chk("rstrd_late_we", {31'd0, reg_we}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
